uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface — parameters
REQ-001 OVERSAMPLE, default 16: number of baud_tick pulses per bit period; legal range 8..32, even values only.
REQ-002 PARITY_EN, default 1: 1 = one parity bit follows the data bits; 0 = no parity bit.
REQ-003 PARITY_ODD, default 0: 0 = even parity; 1 = odd parity; ignored when PARITY_EN=0.

Interface — ports
REQ-004 CLK  input  1  single system clock; all state changes on the rising edge.
REQ-005 RST_n  input  1  asynchronous, active-low reset.
REQ-006 baud_tick  input  1  one-CLK-wide enable at OVERSAMPLE x baud rate.
REQ-007 RX  input  1  serial line, asynchronous to CLK, idles high.
REQ-008 RX_data  output  8  last received byte.
REQ-009 RX_valid  output  1  one-CLK pulse marking a completed frame.
REQ-010 parity_err  output  1  parity mismatch in the last frame.
REQ-011 frame_err  output  1  stop bit sampled low in the last frame.
REQ-012 RX_busy  output  1  high while a frame is being received.

Function
REQ-013 RX shall pass through a 2-flop synchronizer; every FSM decision shall use the synchronized value rx_s (2 CLK of latency).
REQ-014 The FSM shall have exactly the states IDLE, START, DATA, PARITY and STOP, plus a tick counter of width clog2(OVERSAMPLE) and a 3-bit bit counter.
REQ-015 The FSM shall advance and the tick counter shall count only on CLK edges where baud_tick=1.
REQ-016 In IDLE, a tick with rx_s=0 shall move the FSM to START and clear the tick counter.
REQ-017 In START, at tick count OVERSAMPLE/2-1 (mid-bit):
- if rx_s=0, move to DATA and clear both counters;
- if rx_s=1, return to IDLE as a false start, with no outputs changed.
REQ-018 In DATA, at tick count OVERSAMPLE-1:
- sample rx_s into the shift register, LSB first (shift right, new bit enters at [7]);
- clear the tick counter and increment the bit counter;
- after the 8th bit, move to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-019 In PARITY, at tick count OVERSAMPLE-1, the block shall record mismatch = (XOR of data bits ^ sampled bit ^ PARITY_ODD) and move to STOP.
REQ-020 In STOP, at tick count OVERSAMPLE-1, on the same CLK edge the block shall:
- load RX_data from the shift register;
- set frame_err = ~rx_s;
- set parity_err from REQ-019 (0 when PARITY_EN=0);
- pulse RX_valid for exactly one CLK;
- return to IDLE.
REQ-021 A frame with parity or framing errors shall still pulse RX_valid and update RX_data.
REQ-022 RX_data, parity_err and frame_err shall hold their values until the next RX_valid pulse.
REQ-023 RX_busy shall be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-024 A start bit shall be detectable on the first tick after the return to IDLE, so back-to-back frames are received without loss.
REQ-025 A stop bit sampled low shall not be treated as a new start bit; the FSM shall wait in IDLE for rx_s=0 on a later tick.
REQ-026 With baud_tick held low, the FSM and all outputs shall freeze, except RX_valid, which shall fall after its single cycle.

Reset
REQ-027 RST_n=0 shall immediately, without waiting for a clock edge:
- force the state to IDLE;
- clear all counters and the shift register;
- set both synchronizer flops to 1;
- set RX_data=8'h00 and RX_valid=0, parity_err=0, frame_err=0, RX_busy=0.
REQ-028 Reset asserted mid-frame shall abandon the frame with no RX_valid pulse; after release, the next falling edge on RX shall start a new frame.

Verification
REQ-029 The bench shall send 0xA5 with even parity (parity bit 0) and stop=1, and check RX_valid pulses once with RX_data=8'hA5, parity_err=0, frame_err=0.
REQ-030 The bench shall send 0x3C with parity bit 1 (wrong under even parity), and check RX_data=8'h3C, parity_err=1, frame_err=0.
REQ-031 The bench shall send 0xFF with the stop bit low, and check RX_data=8'hFF, frame_err=1, and no second frame while RX stays low.
REQ-032 The bench shall drive a 5-tick low glitch on idle RX, and check the FSM returns to IDLE with no RX_valid and RX_busy high for at most OVERSAMPLE/2 ticks.
REQ-033 The bench shall send 0x55 then 0x81 back-to-back with no idle gap, and check two RX_valid pulses carrying 8'h55 then 8'h81.
REQ-034 The bench shall assert RST_n low during the 4th data bit of 0x0F, then send 0x96, and check all outputs read 0 during reset and the only RX_valid after release carries RX_data=8'h96.

Source files
------------

// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: serial-receiver bus grouping baud tick, line input and frame results
// master: drives baud_tick/rx, observes results; slave: the receiver side
interface uart_rx_fsm_if;
  logic       baud_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;
  modport master (output baud_tick, rx, input rx_data, rx_valid, parity_err, frame_err, rx_busy);
  modport slave  (input baud_tick, rx, output rx_data, rx_valid, parity_err, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampling 8-bit UART receiver with optional parity and framing check
// clk       system clock, rising edge
// rst_n     asynchronous active-low reset
// bus.slave baud_tick/rx in; rx_data, rx_valid, parity_err, frame_err, rx_busy out
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_fsm_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic          s1, rx_s;
  logic [TW-1:0] tick, tick_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    sh, sh_n, data_q, data_n;
  logic          mis, mis_n, perr, perr_n, ferr, ferr_n, valid, valid_n;
  // armed drops after a low stop bit so a stuck-low line cannot start a frame
  logic          armed, armed_n;
  always_comb begin
    state_n = state;
    tick_n  = tick;
    bit_n   = bit_cnt;
    sh_n    = sh;
    mis_n   = mis;
    data_n  = data_q;
    perr_n  = perr;
    ferr_n  = ferr;
    valid_n = 1'b0;
    armed_n = armed;
    if (bus.baud_tick) begin
      tick_n = tick + TW'(1);
      if (rx_s) armed_n = 1'b1;
      case (state)
        IDLE: begin
          tick_n = '0;
          if (!rx_s && armed) state_n = START;
        end
        START: if (tick == T_MID) begin
          tick_n  = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
        DATA: if (tick == T_END) begin
          tick_n = '0;
          bit_n  = bit_cnt + 3'd1;
          sh_n   = {rx_s, sh[7:1]};
          if (bit_cnt == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
        end
        PARITY: if (tick == T_END) begin
          tick_n  = '0;
          mis_n   = ^sh ^ rx_s ^ PARITY_ODD;
          state_n = STOP;
        end
        STOP: if (tick == T_END) begin
          tick_n  = '0;
          data_n  = sh;
          ferr_n  = ~rx_s;
          perr_n  = PARITY_EN & mis;
          valid_n = 1'b1;
          armed_n = rx_s;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      mis     <= 1'b0;
      data_q  <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      valid   <= 1'b0;
      armed   <= 1'b1;
    end else begin
      s1      <= bus.rx;
      rx_s    <= s1;
      state   <= state_n;
      tick    <= tick_n;
      bit_cnt <= bit_n;
      sh      <= sh_n;
      mis     <= mis_n;
      data_q  <= data_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
      valid   <= valid_n;
      armed   <= armed_n;
    end
  end
  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid;
  assign bus.parity_err = perr;
  assign bus.frame_err  = ferr;
  assign bus.rx_busy    = state != IDLE;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames against uart_rx_fsm with hand-computed results
module tb_uart_rx_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nerr = 0;
  int vcnt = 0;
  logic [7:0] last_data;
  logic last_perr, last_ferr;
  uart_rx_fsm_if bus();
  uart_rx_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.baud_tick = 1'b1;
      @(negedge clk);
      bus.baud_tick = 1'b0;
    end
  end
  always @(negedge clk) if (bus.rx_valid === 1'b1) begin
    vcnt++;
    last_data = bus.rx_data;
    last_perr = bus.parity_err;
    last_ferr = bus.frame_err;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (bus.baud_tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    bus.rx = b;
    wait_ticks(16);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask
  task automatic check_frame(input string name, input int v0, input logic [7:0] d, input logic pe, input logic fe);
    nvec++;
    if (vcnt - v0 !== 1) begin nerr++; $display("FAIL %s_count: got %0d want 1", name, vcnt - v0); end
    nvec++;
    if (last_data !== d) begin nerr++; $display("FAIL %s_data: got %h want %h", name, last_data, d); end
    nvec++;
    if (last_perr !== pe) begin nerr++; $display("FAIL %s_perr: got %b want %b", name, last_perr, pe); end
    nvec++;
    if (last_ferr !== fe) begin nerr++; $display("FAIL %s_ferr: got %b want %b", name, last_ferr, fe); end
  endtask
  task automatic check_zero(input string name);
    nvec++;
    if (bus.rx_data !== 8'h00) begin nerr++; $display("FAIL %s_data: got %h want 00", name, bus.rx_data); end
    nvec++;
    if (bus.rx_valid !== 1'b0) begin nerr++; $display("FAIL %s_valid: got %b want 0", name, bus.rx_valid); end
    nvec++;
    if (bus.parity_err !== 1'b0) begin nerr++; $display("FAIL %s_perr: got %b want 0", name, bus.parity_err); end
    nvec++;
    if (bus.frame_err !== 1'b0) begin nerr++; $display("FAIL %s_ferr: got %b want 0", name, bus.frame_err); end
    nvec++;
    if (bus.rx_busy !== 1'b0) begin nerr++; $display("FAIL %s_busy: got %b want 0", name, bus.rx_busy); end
  endtask
  task automatic test_reset;
    bus.rx = 1'b1;
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);
  endtask
  task automatic test_good_frame;
    int v0 = vcnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_ticks(8);
    check_frame("a5", v0, 8'hA5, 1'b0, 1'b0);
  endtask
  task automatic test_parity_err;
    int v0 = vcnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_ticks(8);
    check_frame("3c", v0, 8'h3C, 1'b1, 1'b0);
  endtask
  task automatic test_frame_err;
    int v0 = vcnt;
    send_frame(8'hFF, 1'b0, 1'b0);
    check_frame("ff", v0, 8'hFF, 1'b0, 1'b1);
    wait_ticks(48);
    nvec++;
    if (vcnt - v0 !== 1) begin nerr++; $display("FAIL ff_stuck_low_frames: got %0d want 1", vcnt - v0); end
    nvec++;
    if (bus.rx_busy !== 1'b0) begin nerr++; $display("FAIL ff_stuck_low_busy: got %b want 0", bus.rx_busy); end
    bus.rx = 1'b1;
    wait_ticks(16);
  endtask
  task automatic test_glitch;
    int v0 = vcnt;
    int busy = 0;
    bus.rx = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 5) bus.rx = 1'b1;
      wait_ticks(1);
      if (bus.rx_busy === 1'b1) busy++;
    end
    nvec++;
    if (busy < 1 || busy > 8) begin nerr++; $display("FAIL glitch_busy_ticks: got %0d want 1..8", busy); end
    nvec++;
    if (bus.rx_busy !== 1'b0) begin nerr++; $display("FAIL glitch_idle: got busy %b want 0", bus.rx_busy); end
    nvec++;
    if (vcnt !== v0) begin nerr++; $display("FAIL glitch_valid: got %0d pulses want 0", vcnt - v0); end
    nvec++;
    if (bus.rx_data !== 8'hFF) begin nerr++; $display("FAIL glitch_hold_data: got %h want ff", bus.rx_data); end
  endtask
  task automatic test_back_to_back;
    int v0 = vcnt;
    send_frame(8'h55, 1'b0, 1'b1);
    check_frame("b2b_55", v0, 8'h55, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1);
    check_frame("b2b_81", v0 + 1, 8'h81, 1'b0, 1'b0);
    wait_ticks(16);
  endtask
  task automatic test_reset_mid_frame;
    int v0;
    logic [7:0] d = 8'h0F;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    bus.rx = d[3];
    wait_ticks(8);
    nvec++;
    if (bus.rx_busy !== 1'b1) begin nerr++; $display("FAIL midrst_busy_before: got %b want 1", bus.rx_busy); end
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    v0 = vcnt;
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(32);
    send_frame(8'h96, 1'b0, 1'b1);
    wait_ticks(32);
    check_frame("midrst_96", v0, 8'h96, 1'b0, 1'b0);
  endtask
  initial begin
    test_reset;
    test_good_frame;
    test_parity_err;
    test_frame_err;
    test_glitch;
    test_back_to_back;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
